vga_board_renderer: RTL and testbench
=====================================

Name: vga_board_renderer

Overview:
Parametrised successor to the Tetris VGA renderer. Generates VGA timing from the system clock through a pixel clock-enable, and draws a COLS x ROWS playfield, an NBLK-cell falling piece, and a border. All game inputs are latched once per frame so that an update arriving mid-frame can never tear the picture. Sits between the game-logic FSM and the VGA connector pins.

Parameters:
PIX_DIV, 4, in_clk cycles per pixel (100 MHz to 25 MHz)
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
COLS, 8, playfield columns; XW, 3, column coordinate width
ROWS, 32, playfield rows; YW, 5, row coordinate width
CELL, 12, cell size in pixels (square)
ORG_X, 272, board left edge in pixels; ORG_Y, 48, board top edge in pixels
NBLK, 4, cells per piece
BG_RGB/LOCK_RGB/BORDER_RGB/GRID_RGB, 12'h000/12'h888/12'hFFF/12'h222, colours

Ports:
in_clk  input  1  system clock
in_rst_n  input  1  asynchronous active-low reset
blk_x  input  NBLK*XW  piece column per cell; cell i occupies [i*XW +: XW]
blk_y  input  NBLK*YW  piece row per cell
board_map  input  COLS*ROWS  locked cells; bit y*COLS+x
piece_rgb  input  12  piece colour {R,G,B}
VGA_R/VGA_G/VGA_B  output  4 each  colour
VGA_HS/VGA_VS  output  1 each  sync, active low
frame_start  output  1  one-cycle pulse when inputs are latched

Behaviour:
- Reset is asynchronous and active-low on one clock, in_clk. During reset, and on every register after it: div_cnt=0, h_cnt=0, v_cnt=0, shadows=0, shadow_vld=0, RGB=0, HS=VS=1, frame_start=0. Reset asserted mid-frame returns to these values immediately.
- div_cnt counts 0..PIX_DIV-1 and wraps. pix_ce=1 on the cycle where div_cnt==PIX_DIV-1.
- On pix_ce, h_cnt advances 0..H_TOTAL-1 (800) and wraps. On the h_cnt wrap, v_cnt advances 0..V_TOTAL-1 (525) and wraps.
- Sync: HS low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. VS uses the same rule on v_cnt.
- Snapshot: on the pix_ce where h_cnt==H_TOTAL-1 and v_cnt==V_ACTIVE-1, latch blk_x, blk_y, board_map and piece_rgb into shadow registers, set shadow_vld=1, and pulse frame_start for one in_clk cycle. Drawing uses shadows only.
- Cell tracking is incremental: a sub-pixel counter runs 0..CELL-1 plus a column/row index. No dividers.
- Colour priority per active pixel, highest first:
  1. A piece cell matches and shadow_vld=1: piece_rgb.
  2. The board bit is set: LOCK_RGB.
  3. The pixel is inside the board: BG_RGB.
  4. The pixel is within 2 pixels outside the board rectangle: BORDER_RGB.
  5. Otherwise: 0.
- Outside the active region, RGB=0 unconditionally.
- Piece cells with x>=COLS or y>=ROWS are never drawn.
- Duplicate or overlapping piece cells draw normally.
- RGB, HS and VS are registered together and update on pix_ce, one pixel after the counter value they represent. Sync and colour stay aligned.

Optional Feature:
GRID_LINES_EN:
- Defined: inside the board, the last pixel column and last pixel row of each cell that would otherwise show BG_RGB shows GRID_RGB. Piece, locked and border colours are unaffected.
- Undefined: no grid logic exists and empty cells are uniformly BG_RGB.

Test Plan:
1. Hold in_rst_n low for 100 cycles, then release -> RGB=0 and HS=VS=1 throughout reset. HS low width = 384 in_clk cycles; line period = 3200 cycles.
2. Run 2 frames -> VS low width = 6400 cycles; frame_start period = 1,680,000 cycles with exactly one pulse per frame.
3. Piece at (6,3),(7,3),(7,2),(7,1), piece_rgb=12'hF00, empty board, after first frame_start -> pixel (344,84) = R=F,G=0,B=0; pixel (332,84) = BG_RGB; pixel (270,100) = BORDER_RGB.
4. Set board_map bit 248 (x=0, y=31) -> pixel (272,420) = LOCK_RGB. Move a piece cell to (0,31) -> the same pixel = piece_rgb.
5. Change blk_x while v_cnt=200 -> lines 200-479 still show the old position; the next frame shows the new one. Set blk_x cell to 0 with blk_y=31 and another cell x=7... plus x out of range via XW>3 build -> no piece pixels drawn for the invalid cell.
6. Assert in_rst_n low mid-active-line -> outputs go to reset values within the same cycle. After release, the first frame draws no piece until frame_start.

Source files
------------

// File: rtl/vga_board_renderer_if.sv
// Game-side inputs and VGA pin outputs of vga_board_renderer.
// master drives the game state and watches the pins; slave is the renderer.
interface vga_board_renderer_if #(
    parameter int unsigned NBLK = 4,
    parameter int unsigned XW   = 3,
    parameter int unsigned YW   = 5,
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 32
);
    logic [NBLK*XW-1:0]   blk_x;
    logic [NBLK*YW-1:0]   blk_y;
    logic [COLS*ROWS-1:0] board_map;
    logic [11:0]          piece_rgb;
    logic [3:0]           VGA_R;
    logic [3:0]           VGA_G;
    logic [3:0]           VGA_B;
    logic                 VGA_HS;
    logic                 VGA_VS;
    logic                 frame_start;

    modport master (
        output blk_x, blk_y, board_map, piece_rgb,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start
    );

    modport slave (
        input  blk_x, blk_y, board_map, piece_rgb,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start
    );
endinterface

// File: rtl/vga_board_renderer.sv
// VGA timing generator and playfield/piece/border renderer with a once-per-frame input snapshot.
// Define GRID_LINES_EN to draw grid lines on the last pixel row/column of empty cells.
module vga_board_renderer #(
    parameter int unsigned PIX_DIV    = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter logic [11:0] LOCK_RGB   = 12'h888,
    parameter logic [11:0] BORDER_RGB = 12'hFFF,
`ifdef GRID_LINES_EN
    parameter logic [11:0] GRID_RGB   = 12'h222,
`endif
    parameter int unsigned COLS       = 8,
    parameter int unsigned XW         = 3,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned YW         = 5,
    parameter int unsigned CELL       = 12,
    parameter int unsigned ORG_X      = 272,
    parameter int unsigned ORG_Y      = 48,
    parameter int unsigned NBLK       = 4
) (
    input logic                 in_clk,
    input logic                 in_rst_n,
    vga_board_renderer_if.slave vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned SW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int unsigned MW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1;

    localparam logic [DW-1:0] DivLast  = DW'(PIX_DIV - 1);
    localparam logic [SW-1:0] CellLast = SW'(CELL - 1);
    localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActEnd  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HsBeg    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HsEnd    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BxPre    = HW'(ORG_X - 1);
    localparam logic [HW-1:0] BxBeg    = HW'(ORG_X);
    localparam logic [HW-1:0] BxEnd    = HW'(ORG_X + COLS * CELL);
    localparam logic [HW-1:0] RxBeg    = HW'(ORG_X - 2);
    localparam logic [HW-1:0] RxEnd    = HW'(ORG_X + COLS * CELL + 2);
    localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActEnd  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSnap    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VsBeg    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VsEnd    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] ByPre    = VW'(ORG_Y - 1);
    localparam logic [VW-1:0] ByBeg    = VW'(ORG_Y);
    localparam logic [VW-1:0] ByEnd    = VW'(ORG_Y + ROWS * CELL);
    localparam logic [VW-1:0] RyBeg    = VW'(ORG_Y - 2);
    localparam logic [VW-1:0] RyEnd    = VW'(ORG_Y + ROWS * CELL + 2);

    logic [DW-1:0]        div_q;
    logic [HW-1:0]        h_q;
    logic [VW-1:0]        v_q;
    logic [SW-1:0]        xs_q, ys_q;
    logic [XW:0]          xi_q;
    logic [YW:0]          yi_q;
    logic [NBLK*XW-1:0]   sh_x_q;
    logic [NBLK*YW-1:0]   sh_y_q;
    logic [COLS*ROWS-1:0] sh_map_q;
    logic [11:0]          sh_rgb_q;
    logic                 sh_vld_q;
    logic [11:0]          rgb_q, rgb_d;
    logic                 hs_q, vs_q, fs_q;

    logic                 pix_ce, line_end, snap, active;
    logic                 in_board, in_ring, piece_hit, lock_hit;
    logic [MW-1:0]        map_idx;
    logic [11:0]          empty_rgb;

    assign pix_ce   = (div_q == DivLast);
    assign line_end = pix_ce && (h_q == HLast);
    assign snap     = line_end && (v_q == VSnap);
    assign active   = (h_q < HActEnd) && (v_q < VActEnd);
    assign in_board = (h_q >= BxBeg) && (h_q < BxEnd) && (v_q >= ByBeg) && (v_q < ByEnd);
    assign in_ring  = (h_q >= RxBeg) && (h_q < RxEnd) && (v_q >= RyBeg) && (v_q < RyEnd);
    assign map_idx  = MW'(yi_q * COLS + xi_q);
    assign lock_hit = sh_map_q[map_idx];

`ifdef GRID_LINES_EN
    assign empty_rgb = (xs_q == CellLast || ys_q == CellLast) ? GRID_RGB : BG_RGB;
`else
    assign empty_rgb = BG_RGB;
`endif

    // Cell indices are only meaningful inside the board, which also bounds them below COLS/ROWS.
    always_comb begin
        piece_hit = 1'b0;
        for (int i = 0; i < NBLK; i++) begin
            if ({1'b0, sh_x_q[i*XW +: XW]} == xi_q && {1'b0, sh_y_q[i*YW +: YW]} == yi_q) begin
                piece_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        if (active) begin
            if (in_board) begin
                if (piece_hit && sh_vld_q) rgb_d = sh_rgb_q;
                else if (lock_hit)         rgb_d = LOCK_RGB;
                else                       rgb_d = empty_rgb;
            end else if (in_ring) begin
                rgb_d = BORDER_RGB;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            xi_q     <= '0;
            yi_q     <= '0;
            sh_x_q   <= '0;
            sh_y_q   <= '0;
            sh_map_q <= '0;
            sh_rgb_q <= '0;
            sh_vld_q <= 1'b0;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            div_q <= pix_ce ? '0 : div_q + 1'b1;
            fs_q  <= snap;
            if (pix_ce) begin
                h_q   <= (h_q == HLast) ? '0 : h_q + 1'b1;
                rgb_q <= rgb_d;
                hs_q  <= !((h_q >= HsBeg) && (h_q < HsEnd));
                vs_q  <= !((v_q >= VsBeg) && (v_q < VsEnd));
                // Sub-cell counters restart one pixel before the board edge so they align on it.
                if (h_q == BxPre) begin
                    xs_q <= '0;
                    xi_q <= '0;
                end else if (xs_q == CellLast) begin
                    xs_q <= '0;
                    xi_q <= xi_q + 1'b1;
                end else begin
                    xs_q <= xs_q + 1'b1;
                end
            end
            if (line_end) begin
                v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
                if (v_q == ByPre) begin
                    ys_q <= '0;
                    yi_q <= '0;
                end else if (ys_q == CellLast) begin
                    ys_q <= '0;
                    yi_q <= yi_q + 1'b1;
                end else begin
                    ys_q <= ys_q + 1'b1;
                end
            end
            if (snap) begin
                sh_x_q   <= vif.blk_x;
                sh_y_q   <= vif.blk_y;
                sh_map_q <= vif.board_map;
                sh_rgb_q <= vif.piece_rgb;
                sh_vld_q <= 1'b1;
            end
        end
    end

    assign vif.VGA_R       = rgb_q[11:8];
    assign vif.VGA_G       = rgb_q[7:4];
    assign vif.VGA_B       = rgb_q[3:0];
    assign vif.VGA_HS      = hs_q;
    assign vif.VGA_VS      = vs_q;
    assign vif.frame_start = fs_q;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer on a shrunken timing/board so whole frames fit in a short run.
// A behavioural pixel model pushes expected outputs to a scoreboard popped as each pixel emerges.
module tb_vga_board_renderer;
    localparam int unsigned PIX_DIV  = 2;
    localparam int unsigned H_ACTIVE = 40;
    localparam int unsigned H_FP     = 2;
    localparam int unsigned H_SYNC   = 4;
    localparam int unsigned H_BP     = 2;
    localparam int unsigned V_ACTIVE = 30;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 1;
    localparam int unsigned COLS     = 4;
    localparam int unsigned XW       = 3;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned YW       = 3;
    localparam int unsigned CELL     = 3;
    localparam int unsigned ORG_X    = 6;
    localparam int unsigned ORG_Y    = 6;
    localparam int unsigned NBLK     = 4;
    localparam int H_TOTAL = 48;
    localparam int V_TOTAL = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_board_renderer_if #(.NBLK(NBLK), .XW(XW), .YW(YW), .COLS(COLS), .ROWS(ROWS)) vif ();

    vga_board_renderer #(
        .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLS(COLS), .XW(XW), .ROWS(ROWS), .YW(YW), .CELL(CELL),
        .ORG_X(ORG_X), .ORG_Y(ORG_Y), .NBLK(NBLK)
    ) dut (
        .in_clk  (clk),
        .in_rst_n(rst_n),
        .vif     (vif)
    );

    typedef struct {
        logic [13:0] val;
        int          h;
        int          v;
    } exp_t;

    exp_t                 sb[$];
    int                   n_checks = 0;
    int                   n_errors = 0;
    int                   ref_div = 0, ref_h = 0, ref_v = 0;
    int                   frames_exp = 0, frames_got = 0;
    logic [NBLK*XW-1:0]   sh_x = '0;
    logic [NBLK*YW-1:0]   sh_y = '0;
    logic [COLS*ROWS-1:0] sh_map = '0;
    logic [11:0]          sh_rgb = '0;
    logic                 sh_vld = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {rgb, hs, vs} for the pixel at counter position (h, v), computed geometrically.
    function automatic logic [13:0] model_px(input int h, input int v);
        logic [11:0] rgb = 12'h000;
        logic        hs, vs;
        if (h < H_ACTIVE && v < V_ACTIVE) begin
            if (h >= ORG_X && h < ORG_X + COLS * CELL && v >= ORG_Y && v < ORG_Y + ROWS * CELL) begin
                int cx = (h - ORG_X) / CELL;
                int cy = (v - ORG_Y) / CELL;
                bit hit = 1'b0;
                for (int i = 0; i < NBLK; i++)
                    if (int'(sh_x[i*XW +: XW]) == cx && int'(sh_y[i*YW +: YW]) == cy) hit = 1'b1;
                if (hit && sh_vld)             rgb = sh_rgb;
                else if (sh_map[cy*COLS + cx]) rgb = 12'h888;
                else                           rgb = 12'h000;
            end else if (h >= ORG_X - 2 && h < ORG_X + COLS * CELL + 2 &&
                         v >= ORG_Y - 2 && v < ORG_Y + ROWS * CELL + 2) begin
                rgb = 12'hFFF;
            end
        end
        hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        return {rgb, hs, vs};
    endfunction

    // Model and checker: at each falling edge replay the rising edge that just happened.
    initial begin
        forever begin
            logic exp_fs;
            exp_t e;
            @(negedge clk);
            if (!rst_n) begin
                check_val("rst_rgb", {vif.VGA_R, vif.VGA_G, vif.VGA_B}, 12'h000);
                check_val("rst_sync", {vif.VGA_HS, vif.VGA_VS}, 2'b11);
                check_val("rst_frame_start", vif.frame_start, 1'b0);
                ref_div = 0; ref_h = 0; ref_v = 0;
                sh_x = '0; sh_y = '0; sh_map = '0; sh_rgb = '0; sh_vld = 1'b0;
                sb.delete();
            end else begin
                exp_fs = 1'b0;
                if (ref_div == PIX_DIV - 1) begin
                    ref_div = 0;
                    e.val = model_px(ref_h, ref_v);
                    e.h = ref_h;
                    e.v = ref_v;
                    sb.push_back(e);
                    if (ref_h == H_TOTAL - 1 && ref_v == V_ACTIVE - 1) begin
                        sh_x = vif.blk_x; sh_y = vif.blk_y; sh_map = vif.board_map;
                        sh_rgb = vif.piece_rgb; sh_vld = 1'b1;
                        exp_fs = 1'b1;
                        frames_exp++;
                    end
                    if (ref_h == H_TOTAL - 1) begin
                        ref_h = 0;
                        ref_v = (ref_v == V_TOTAL - 1) ? 0 : ref_v + 1;
                    end else begin
                        ref_h++;
                    end
                    e = sb.pop_front();
                    check_val($sformatf("pixel(%0d,%0d)", e.h, e.v),
                              {vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HS, vif.VGA_VS}, e.val);
                end else begin
                    ref_div++;
                end
                check_val("frame_start", vif.frame_start, exp_fs);
                if (vif.frame_start) frames_got++;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pos(input int v, input int h);
        bit found = 1'b0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (ref_v == v && ref_h == h) found = 1'b1;
        end
        check_val("wait_pos", found, 1'b1);
    endtask

    initial begin
        // Cells (3,1),(3,2),(2,2),(3,3); cell i sits at [i*XW +: XW].
        vif.blk_x     = {3'd3, 3'd2, 3'd3, 3'd3};
        vif.blk_y     = {3'd3, 3'd2, 3'd2, 3'd1};
        vif.piece_rgb = 12'hF00;
        vif.board_map = '0;
        run(20);
        rst_n = 1'b1;
        run(4000);
        // Locked cells at (0,3),(1,1),(3,0) plus (3,3) hidden under the piece.
        vif.board_map = 16'h9028;
        run(3400);
        // Mid-frame move: visible only from the next frame; (1,5) and (5,1) are off-board.
        wait_pos(10, 0);
        vif.blk_x = {3'd5, 3'd2, 3'd1, 3'd0};
        vif.blk_y = {3'd1, 3'd2, 3'd5, 3'd3};
        run(6600);
        // Duplicate cells and a fully out-of-range cell, new colour.
        vif.blk_x     = {3'd1, 3'd7, 3'd2, 3'd2};
        vif.blk_y     = {3'd0, 3'd7, 3'd2, 3'd2};
        vif.piece_rgb = 12'h0F0;
        run(3400);
        // Reset while a piece pixel (column 2, row 2) is on the pins.
        wait_pos(12, 13);
        check_val("pre_rst_rgb", {vif.VGA_R, vif.VGA_G, vif.VGA_B}, 12'h0F0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_rgb", {vif.VGA_R, vif.VGA_G, vif.VGA_B}, 12'h000);
        check_val("async_rst_sync", {vif.VGA_HS, vif.VGA_VS}, 2'b11);
        run(10);
        rst_n = 1'b1;
        run(5000);
        check_val("frame_count", frames_got, frames_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
